// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS checker: lock state, standard
// polynomial tap masks and a saturating 32-bit adder.
package prbs_pkg;

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Tap masks over a POL_W+1-bit window; bit k taps the bit k steps older.
  localparam logic [31:0] PRBS7  = 32'h0000_00C0;
  localparam logic [31:0] PRBS15 = 32'h0000_C000;
  localparam logic [31:0] PRBS31 = 32'h9000_0000;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// Combinational PRBS word predictor: extends the last POL_W received bits
// by DW new bits, oldest bit in pred_o[DW-1], newest in pred_o[0].
module prbs_predict #(
  parameter logic [31:0] POL_MASK = 32'h0000_00C0,
  parameter int          POL_W    = 7,
  parameter int          DW       = 16
) (
  input  logic [POL_W-1:0] s_i,
  output logic [DW-1:0]    pred_o
);

  localparam logic [POL_W:0] TAPS = POL_MASK[POL_W:0];

  logic [DW+POL_W-1:0] win;

  // Each new bit depends only on older (higher-index) bits, so a single
  // descending pass resolves the whole word.
  always_comb begin
    win = {s_i, {DW{1'b0}}};
    for (int i = DW - 1; i >= 0; i--) begin
      win[i] = ^(win[i +: POL_W+1] & TAPS);
    end
    pred_o = win[DW-1:0];
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: seeks lock on a self-synchronising prediction, then
// free-runs its own LFSR and reports per-word bit errors and a saturating count.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter logic [31:0] POL_MASK = PRBS7,
  parameter int          POL_W    = 7,
  parameter int          DW       = 16,
  parameter int          LOCK_CNT = 4,
  parameter int          LOSS_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  input  logic          err_clr,
  output logic          locked,
  output logic          err_word,
  output logic [DW-1:0] err_mask,
  output logic [31:0]   err_cnt
);

  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CW      = $clog2(RUN_MAX + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_CNT - 1);

  state_e            state_q, state_d;
  logic [POL_W-1:0]  s_q, s_d;
  logic              primed_q, primed_d;
  logic [CW-1:0]     good_q, good_d;
  logic [CW-1:0]     bad_q, bad_d;
  logic              err_word_q, err_word_d;
  logic [DW-1:0]     err_mask_q, err_mask_d;
  logic [31:0]       err_cnt_q, err_cnt_d;

  logic [DW-1:0]     pred;
  logic [DW-1:0]     diff;
  logic              word_bad;
  logic              match;
  logic              lock_hit;
  logic              loss_hit;

  prbs_predict #(
    .POL_MASK(POL_MASK),
    .POL_W   (POL_W),
    .DW      (DW)
  ) u_predict (
    .s_i   (s_q),
    .pred_o(pred)
  );

  assign diff     = data_in ^ pred;
  assign word_bad = |diff;
  // An all-zero state predicts all zeros, so it must never count as a match.
  assign match    = !word_bad && (s_q != '0);
  assign lock_hit = data_valid && primed_q && match && (good_q == LOCK_LAST);
  assign loss_hit = data_valid && word_bad && (bad_q == LOSS_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEEK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEEK:    if (lock_hit) state_d = LOCKED;
      LOCKED:  if (loss_hit) state_d = SEEK;
      default: state_d = SEEK;
    endcase
  end

  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    s_d        = s_q;
    primed_d   = primed_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_word_d = 1'b0;
    err_mask_d = err_mask_q;
    err_cnt_d  = err_cnt_q;
    if (data_valid) begin
      if (state_q == SEEK) begin
        err_mask_d = '0;
        s_d        = data_in[POL_W-1:0];
        bad_d      = '0;
        if (!primed_q)  primed_d = 1'b1;
        else if (match) good_d   = lock_hit ? '0 : good_q + 1'b1;
        else            good_d   = '0;
      end else begin
        // Self-running: the prediction, not the received word, advances S.
        s_d        = pred[POL_W-1:0];
        err_mask_d = diff;
        err_word_d = word_bad;
        err_cnt_d  = sat_add(err_cnt_q, 32'($countones(diff)));
        if (loss_hit) begin
          primed_d = 1'b0;
          good_d   = '0;
          bad_d    = '0;
        end else if (word_bad) begin
          bad_d = bad_q + 1'b1;
        end else begin
          bad_d = '0;
        end
      end
    end
    if (err_clr) err_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q        <= '0;
      primed_q   <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
      err_word_q <= 1'b0;
      err_mask_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      s_q        <= s_d;
      primed_q   <= primed_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_word_q <= err_word_d;
      err_mask_q <= err_mask_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign err_word = err_word_q;
  assign err_mask = err_mask_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: directed scenarios plus a randomized
// segment, compared every cycle against a bit-serial reference model.
module tb_prbs_checker;
  import prbs_pkg::*;

  localparam logic [31:0] MASK     = PRBS7;
  localparam int          PW       = 7;
  localparam int          DW       = 16;
  localparam int          LOCK_CNT = 4;
  localparam int          LOSS_CNT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          err_clr = 1'b0;
  logic          locked;
  logic          err_word;
  logic [DW-1:0] err_mask;
  logic [31:0]   err_cnt;

  always #5 clk = ~clk;

  prbs_checker #(
    .POL_MASK(MASK),
    .POL_W   (PW),
    .DW      (DW),
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_word  (err_word),
    .err_mask  (err_mask),
    .err_cnt   (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_locked;
  logic [PW-1:0] m_s;
  bit            m_primed;
  int            m_good;
  int            m_bad;
  bit            m_word;
  logic [DW-1:0] m_mask;
  logic [31:0]   m_cnt;

  logic [PW-1:0] gen_s;

  // Bit-serial view: each new bit is the XOR of the tapped older bits,
  // where mask bit k selects the bit k positions back in time.
  function automatic logic [DW-1:0] model_predict(input logic [PW-1:0] s);
    bit            seq[$];
    bit            b;
    logic [DW-1:0] w;
    for (int k = 0; k < PW; k++) seq.push_back(s[PW-1-k]);
    for (int n = 0; n < DW; n++) begin
      b = 1'b0;
      for (int k = 1; k <= PW; k++)
        if (MASK[k]) b = b ^ seq[seq.size() - k];
      seq.push_back(b);
      w[DW-1-n] = b;
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] next_word();
    logic [DW-1:0] w;
    w = model_predict(gen_s);
    gen_s = w[PW-1:0];
    return w;
  endfunction

  task automatic model_update(input logic [DW-1:0] d, input bit v, input bit c, input bit r);
    logic [DW-1:0] p;
    logic [DW-1:0] x;
    longint        sum;
    if (r) begin
      m_locked = 0; m_s = '0; m_primed = 0; m_good = 0; m_bad = 0;
      m_word = 0; m_mask = '0; m_cnt = '0;
      return;
    end
    m_word = 0;
    if (v) begin
      p = model_predict(m_s);
      if (!m_locked) begin
        m_mask = '0;
        if (!m_primed) m_primed = 1;
        else if (d == p && m_s != '0) m_good++;
        else m_good = 0;
        m_s = d[PW-1:0];
        if (m_good == LOCK_CNT) begin
          m_locked = 1; m_good = 0; m_bad = 0;
        end
      end else begin
        x = d ^ p;
        m_mask = x;
        m_word = (x != '0);
        sum = longint'(m_cnt) + $countones(x);
        m_cnt = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
        if (x != '0) m_bad++;
        else m_bad = 0;
        m_s = p[PW-1:0];
        if (m_bad == LOSS_CNT) begin
          m_locked = 0; m_primed = 0; m_good = 0; m_bad = 0;
        end
      end
    end
    if (c) m_cnt = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [DW-1:0] d, input bit v, input bit c, input bit r);
    data_in = d; data_valid = v; err_clr = c; rst = r;
    @(posedge clk);
    #1;
    model_update(d, v, c, r);
    chk("locked", {31'b0, locked}, {31'b0, m_locked});
    chk("err_word", {31'b0, err_word}, {31'b0, m_word});
    chk("err_mask", {16'b0, err_mask}, {16'b0, m_mask});
    chk("err_cnt", err_cnt, m_cnt);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            v;
    bit            c;
    int            nv;

    // Reset values
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);
    chk("rst_locked", {31'b0, locked}, 32'd0);
    chk("rst_cnt", err_cnt, 32'd0);

    // Clean stream seeded 7F: locked after the 5th word, no errors over 1000
    gen_s = 7'h7F;
    for (int w = 1; w <= 1000; w++) begin
      step(next_word(), 1, 0, 0);
      if (w <= 6) chk("lock_timing", {31'b0, locked}, (w >= 5) ? 32'd1 : 32'd0);
    end
    chk("clean_cnt", err_cnt, 32'd0);
    chk("clean_locked", {31'b0, locked}, 32'd1);

    // Single bit-3 flip
    step(next_word() ^ 16'h0008, 1, 0, 0);
    chk("flip_word", {31'b0, err_word}, 32'd1);
    chk("flip_mask", {16'b0, err_mask}, 32'h0008);
    chk("flip_cnt", err_cnt, 32'd1);
    chk("flip_locked", {31'b0, locked}, 32'd1);
    step(next_word(), 1, 0, 0);
    chk("flip_next_word", {31'b0, err_word}, 32'd0);
    step(next_word(), 1, 1, 0);
    chk("clr_cnt", err_cnt, 32'd0);

    // Four inverted words drop lock; clean stream relocks after 5 words
    for (int k = 0; k < 4; k++) begin
      step(~next_word(), 1, 0, 0);
      chk("inv_locked", {31'b0, locked}, (k < 3) ? 32'd1 : 32'd0);
    end
    chk("inv_cnt", err_cnt, 32'd64);
    for (int k = 1; k <= 5; k++) begin
      step(next_word(), 1, 0, 0);
      chk("relock", {31'b0, locked}, (k == 5) ? 32'd1 : 32'd0);
    end

    // Randomized gaps, bit errors, inverted words and clears
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      if (v) begin
        d = next_word();
        if ($urandom_range(0, 7) == 0) d = d ^ (16'd1 << $urandom_range(0, 15));
        if ($urandom_range(0, 29) == 0) d = ~d;
      end else begin
        d = 16'($urandom);
      end
      step(d, v, c, 0);
    end

    // Saturation from a preloaded count, then clear beats a simultaneous error
    for (int k = 0; k < 6; k++) step(next_word(), 1, 0, 0);
    chk("sat_pre_locked", {31'b0, locked}, 32'd1);
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1 release dut.err_cnt_q;
    step(next_word() ^ 16'h0001, 1, 0, 0);
    chk("sat_reach", err_cnt, 32'hFFFF_FFFF);
    step(next_word() ^ 16'h0300, 1, 0, 0);
    chk("sat_hold", err_cnt, 32'hFFFF_FFFF);
    step(next_word(), 1, 0, 0);
    step(next_word() ^ 16'h8000, 1, 1, 0);
    chk("clr_priority", err_cnt, 32'd0);

    // All-zero stream never locks
    step('0, 0, 0, 1);
    for (int k = 0; k < 100; k++) begin
      step('0, 1, 0, 0);
      chk("zero_locked", {31'b0, locked}, 32'd0);
    end

    // Alternate valid cycles: lock counts valid words only; rst abandons lock
    step('0, 0, 0, 1);
    gen_s = 7'h7F;
    nv = 0;
    for (int k = 0; k < 14; k++) begin
      v = (k % 2 == 0);
      if (v) nv++;
      step(v ? next_word() : 16'($urandom), v, 0, 0);
      chk("alt_lock", {31'b0, locked}, (nv >= 5) ? 32'd1 : 32'd0);
    end
    step(next_word(), 1, 0, 1);
    chk("rst_unlock", {31'b0, locked}, 32'd0);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      v = (k % 2 == 0);
      if (v) nv++;
      step(v ? next_word() : 16'($urandom), v, 0, 0);
      chk("alt_relock", {31'b0, locked}, (nv >= 5) ? 32'd1 : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
